// File: rtl/syn_vga_pxl_wrtr.sv
// Frame-buffer write agent: packs 8-bit (x,y) pixel writes into 16-bit SRAM words.
// Adjacent even/odd pixels that arrive back to back share one req/ack write.
module syn_vga_pxl_wrtr #(
    parameter int P_H_RES       = 640,
    parameter int P_V_RES       = 480,
    parameter int P_X_W         = 10,
    parameter int P_Y_W         = 9,
    parameter int P_PXL_W       = 8,
    parameter int P_SRAM_ADDR_W = 18,
    parameter int P_SRAM_DATA_W = 16,
    parameter int P_DROP_CNT_W  = 16
) (
    input  logic                     clk_ir,
    input  logic                     rst_il,
    input  logic                     pxl_vld_ih,
    output logic                     pxl_rdy_oh,
    input  logic [P_X_W-1:0]         pxl_x_id,
    input  logic [P_Y_W-1:0]         pxl_y_id,
    input  logic [P_PXL_W-1:0]       pxl_data_id,
    output logic                     sram_req_oh,
    input  logic                     sram_ack_ih,
    output logic [P_SRAM_ADDR_W-1:0] sram_addr_od,
    output logic [P_SRAM_DATA_W-1:0] sram_wdata_od,
    output logic [1:0]               sram_be_od,
    output logic                     busy_oh,
    output logic [P_DROP_CNT_W-1:0]  drop_cnt_od
);

    typedef struct packed {
        logic [P_SRAM_ADDR_W-1:0] addr;
        logic [P_SRAM_DATA_W-1:0] data;
        logic [1:0]               be;
    } word_t;

    typedef enum logic [1:0] {IDLE, HOLD, REQ} state_t;

    state_t                  state;
    word_t                   hold;
    word_t                   nxt;
    logic                    nxt_vld;
    logic [P_DROP_CNT_W-1:0] drop_cnt;

    word_t in_w;
    logic  in_range;
    logic  accept;
    logic  mergeable;

    assign in_range = (32'(pxl_x_id) < 32'(P_H_RES)) && (32'(pxl_y_id) < 32'(P_V_RES));

    always_comb begin
        in_w      = '0;
        in_w.addr = P_SRAM_ADDR_W'(pxl_y_id) * P_SRAM_ADDR_W'(P_H_RES / 2)
                  + P_SRAM_ADDR_W'(pxl_x_id[P_X_W-1:1]);
        if (pxl_x_id[0]) begin
            in_w.data[2*P_PXL_W-1:P_PXL_W] = pxl_data_id;
            in_w.be                        = 2'b10;
        end else begin
            in_w.data[P_PXL_W-1:0] = pxl_data_id;
            in_w.be                = 2'b01;
        end
    end

    // Only the free lane of the same word may merge; a repeated lane is a new write.
    assign mergeable  = in_range && (in_w.addr == hold.addr) && ((in_w.be & hold.be) == 2'b00);
    assign pxl_rdy_oh = (state != REQ) || !nxt_vld;
    assign accept     = pxl_vld_ih && pxl_rdy_oh;

    assign sram_req_oh   = (state == REQ);
    assign sram_addr_od  = hold.addr;
    assign sram_wdata_od = hold.data;
    assign sram_be_od    = hold.be;
    assign busy_oh       = (state != IDLE) || nxt_vld;
    assign drop_cnt_od   = drop_cnt;

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state    <= IDLE;
            hold     <= '0;
            nxt      <= '0;
            nxt_vld  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept && !in_range && (drop_cnt != '1))
                drop_cnt <= drop_cnt + P_DROP_CNT_W'(1);

            case (state)
                IDLE: begin
                    if (accept && in_range) begin
                        hold  <= in_w;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    state <= REQ;
                    if (accept && in_range) begin
                        if (mergeable) begin
                            hold.data <= hold.data | in_w.data;
                            hold.be   <= hold.be | in_w.be;
                        end else begin
                            nxt     <= in_w;
                            nxt_vld <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (sram_ack_ih) begin
                        if (nxt_vld) begin
                            hold    <= nxt;
                            nxt_vld <= 1'b0;
                            state   <= HOLD;
                        end else if (accept && in_range) begin
                            hold  <= in_w;
                            state <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept && in_range) begin
                        nxt     <= in_w;
                        nxt_vld <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
